// File: rtl/dcache2_evict_ctrl_pkg.sv
// Shared types and constants for the L2 data-cache eviction controller.
// Holds the sequencer state encoding and the line index width.
package dcache2_evict_ctrl_pkg;

    localparam int DC2_LINE_AW = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD,
        ST_CHK,
        ST_WB,
        ST_INS,
        ST_FRD,
        ST_FCHK,
        ST_FWB,
        ST_FCLR
    } dc2_evict_state_t;

endpackage

// File: rtl/dcache2_flush_walker.sv
// Flush walker line index counter with wrap and last-line detect.
// Ports: clk/rst, start_i clears index, step_i advances, idx_o, last_o.
module dcache2_flush_walker
    import dcache2_evict_ctrl_pkg::*;
#(
    parameter int AW = DC2_LINE_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          step_i,
    output logic [AW-1:0] idx_o,
    output logic          last_o
);

    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (start_i) begin
            idx_d = '0;
        end else if (step_i) begin
            // Natural wrap after the top line leaves the counter at 0
            idx_d = idx_q + {{(AW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == {AW{1'b1}});

endmodule

// File: rtl/dcache2_evict_ctrl.sv
// Eviction/fill sequencer in front of the L2 dirty-bit array: checks the
// victim's dirty bit, writes it back if needed, then inserts the new state.
// Ports: fill_* request/handshake, dirty_rd_* array read port, ins_* insert
// port 0, wb_* writeback handshake, flush_req_i/flush_done_o walker control.
// Macro DC2_EVICT_FLUSH_EN enables the flush walker; otherwise flush_req_i
// is ignored and flush_done_o is tied low.
module dcache2_evict_ctrl
    import dcache2_evict_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DC2_LINE_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_req_i,
    input  logic [ADDR_WIDTH-1:0] fill_addr_i,
    input  logic                  fill_dirty_i,
    output logic                  fill_ready_o,
    output logic                  fill_done_o,
    output logic                  dirty_rd_en_o,
    output logic [ADDR_WIDTH-1:0] dirty_rd_addr_o,
    input  logic                  dirty_rd_data_i,
    output logic                  ins_en_o,
    output logic [ADDR_WIDTH-1:0] ins_addr_o,
    output logic                  ins_dirty_o,
    output logic                  wb_req_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    input  logic                  wb_ack_i,
    input  logic                  flush_req_i,
    output logic                  flush_done_o
);

    dc2_evict_state_t      state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  dirty_q, dirty_d;
    // Read address is held between reads so the array sees a stable index
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

`ifdef DC2_EVICT_FLUSH_EN
    logic                  fdone_q, fdone_d;
    logic                  walk_start;
    logic                  walk_step;
    logic [ADDR_WIDTH-1:0] walk_idx;
    logic                  walk_last;

    dcache2_flush_walker #(
        .AW(ADDR_WIDTH)
    ) u_walker (
        .clk    (clk),
        .rst    (rst),
        .start_i(walk_start),
        .step_i (walk_step),
        .idx_o  (walk_idx),
        .last_o (walk_last)
    );

    assign flush_done_o = fdone_q;
`else
    logic unused_flush;
    assign unused_flush = flush_req_i;
    assign flush_done_o = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        dirty_d         = dirty_q;
        rd_addr_d       = rd_addr_q;
        fill_ready_o    = 1'b0;
        fill_done_o     = 1'b0;
        dirty_rd_en_o   = 1'b0;
        dirty_rd_addr_o = rd_addr_q;
        ins_en_o        = 1'b0;
        ins_addr_o      = '0;
        ins_dirty_o     = 1'b0;
        wb_req_o        = 1'b0;
        wb_addr_o       = '0;
`ifdef DC2_EVICT_FLUSH_EN
        fdone_d         = 1'b0;
        walk_start      = 1'b0;
        walk_step       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                fill_ready_o = 1'b1;
                // A pending fill takes priority over starting a flush
                if (fill_req_i) begin
                    addr_d  = fill_addr_i;
                    dirty_d = fill_dirty_i;
                    state_d = ST_RD;
                end
`ifdef DC2_EVICT_FLUSH_EN
                else if (flush_req_i) begin
                    walk_start = 1'b1;
                    state_d    = ST_FRD;
                end
`endif
            end
            ST_RD: begin
                dirty_rd_en_o   = 1'b1;
                dirty_rd_addr_o = addr_q;
                rd_addr_d       = addr_q;
                state_d         = ST_CHK;
            end
            ST_CHK: begin
                state_d = dirty_rd_data_i ? ST_WB : ST_INS;
            end
            ST_WB: begin
                wb_req_o  = 1'b1;
                wb_addr_o = addr_q;
                if (wb_ack_i) begin
                    state_d = ST_INS;
                end
            end
            ST_INS: begin
                ins_en_o    = 1'b1;
                ins_addr_o  = addr_q;
                ins_dirty_o = dirty_q;
                fill_done_o = 1'b1;
                state_d     = ST_IDLE;
            end
`ifdef DC2_EVICT_FLUSH_EN
            ST_FRD: begin
                dirty_rd_en_o   = 1'b1;
                dirty_rd_addr_o = walk_idx;
                rd_addr_d       = walk_idx;
                state_d         = ST_FCHK;
            end
            ST_FCHK: begin
                if (dirty_rd_data_i) begin
                    state_d = ST_FWB;
                end else begin
                    walk_step = 1'b1;
                    fdone_d   = walk_last;
                    state_d   = walk_last ? ST_IDLE : ST_FRD;
                end
            end
            ST_FWB: begin
                wb_req_o  = 1'b1;
                wb_addr_o = walk_idx;
                if (wb_ack_i) begin
                    state_d = ST_FCLR;
                end
            end
            ST_FCLR: begin
                ins_en_o    = 1'b1;
                ins_addr_o  = walk_idx;
                ins_dirty_o = 1'b0;
                walk_step   = 1'b1;
                fdone_d     = walk_last;
                state_d     = walk_last ? ST_IDLE : ST_FRD;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            dirty_q   <= 1'b0;
            rd_addr_q <= '0;
`ifdef DC2_EVICT_FLUSH_EN
            fdone_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dirty_q   <= dirty_d;
            rd_addr_q <= rd_addr_d;
`ifdef DC2_EVICT_FLUSH_EN
            fdone_q   <= fdone_d;
`endif
        end
    end

endmodule
